// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-sequence detector with a maskable pattern,
// overlap/non-overlap detection and a saturating match counter.
module seq_detector_prog #(
    parameter int                   PAT_LEN      = 5,
    parameter logic [PAT_LEN-1:0]   PAT_DEFAULT  = 5'b10011,
    parameter logic [PAT_LEN-1:0]   MASK_DEFAULT = '0,
    parameter int                   CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic [PAT_LEN-1:0] mask_in,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FULL    = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_FILLING = 2'd1;
    localparam logic [1:0] S_ARMED   = 2'd2;

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_nx;
    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] mask;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_nx;
    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic               hit;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_nx;

    always_comb begin
        hist_nx  = hist;
        fill_nx  = fill;
        state_nx = state;
        hit      = 1'b0;
        cnt_base = cnt_clr ? '0 : match_cnt;
        if (pat_load) begin
            // a reload discards the bit sampled on the same edge
            hist_nx  = '0;
            fill_nx  = '0;
            state_nx = S_EMPTY;
        end else if (in_valid) begin
            hist_nx = {hist[PAT_LEN-2:0], in};
            fill_nx = (fill == FULL) ? FULL : fill + 1'b1;
            hit     = (fill_nx == FULL) &&
                      (((hist_nx ^ pat) & ~mask) == '0);
            if (hit && !overlap) begin
                fill_nx  = '0;
                state_nx = S_EMPTY;
            end else if (fill_nx == FULL) begin
                state_nx = S_ARMED;
            end else begin
                state_nx = S_FILLING;
            end
        end
        cnt_nx = (hit && cnt_base != CNT_MAX) ? cnt_base + 1'b1 : cnt_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            state     <= S_EMPTY;
            pat       <= PAT_DEFAULT;
            mask      <= MASK_DEFAULT;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            hist      <= hist_nx;
            fill      <= fill_nx;
            state     <= state_nx;
            match     <= hit;
            match_cnt <= cnt_nx;
            if (pat_load) begin
                pat  <= pat_in;
                mask <= mask_in;
            end
        end
    end

    assign armed = (state == S_ARMED);

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Parametrised, runtime-programmable serial bit-sequence detector; next generation of the fixed 5-state MATCH FSM used in the advanced FSM benchmarks.
- Consumes one serial bit per qualified cycle and asserts MATCH when the last PAT_LEN bits equal a loadable pattern; bits can be masked as don't-care.
- Overlapping or non-overlapping detection is selected at runtime; a saturating counter records the number of matches.
- Sits between a serial input source and control or verification logic.

Parameters:
- PAT_LEN, 5, pattern length in bits (2..32).
- PAT_DEFAULT, 5'b10011, pattern loaded at reset; MSB is the oldest bit.
- MASK_DEFAULT, 0, care-mask loaded at reset; a 1 marks a don't-care bit.
- CNT_W, 8, width of MATCH_CNT.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN  in  1  serial data bit.
- IN_VALID  in  1  IN is sampled only when this is 1.
- OVERLAP  in  1  1 = overlapping detection; 0 = non-overlapping.
- PAT_LOAD  in  1  1-cycle strobe that loads PAT_IN and MASK_IN.
- PAT_IN  in  PAT_LEN  new pattern.
- MASK_IN  in  PAT_LEN  new don't-care mask.
- CNT_CLR  in  1  clears MATCH_CNT.
- MATCH  out  1  registered 1-cycle match pulse.
- MATCH_CNT  out  CNT_W  saturating match count.
- ARMED  out  1  history holds PAT_LEN valid bits.

Behaviour:
- Reset (synchronous, active-high): on the rising edge with RST=1:
  - history and fill count cleared; state EMPTY.
  - pattern and mask registers set to PAT_DEFAULT and MASK_DEFAULT.
  - MATCH=0, MATCH_CNT=0, ARMED=0.
  - RST has priority over all other inputs.
- History: on each edge with IN_VALID=1, hist <= {hist[PAT_LEN-2:0], IN}; the newest bit is at bit 0.
  - fill count increments and saturates at PAT_LEN.
  - IN_VALID=0 holds all state, and MATCH drops to 0.
- State machine: EMPTY (fill=0), FILLING (0<fill<PAT_LEN), ARMED (fill=PAT_LEN).
  - EMPTY->FILLING on the first valid bit.
  - FILLING->ARMED on the valid bit that brings fill to PAT_LEN.
  - ARMED stays ARMED in overlap mode; any state goes to EMPTY on PAT_LOAD.
  - ARMED output = (state==ARMED), registered.
- Match condition: evaluated on the updated history, i.e. including the bit sampled at this edge.
  - Requires fill reaching PAT_LEN at this edge and ((hist_next ^ pattern) & ~mask) == 0.
  - MATCH is registered: high for exactly the one cycle following the edge that sampled the completing bit.
- OVERLAP=1: history is kept after a match, so the next match can come as early as the next valid bit.
- OVERLAP=0: on a match edge, fill count is set to 0 and state goes to EMPTY; the next match needs PAT_LEN fresh bits.
  - OVERLAP is sampled each edge; changing it mid-stream takes effect at the next match.
- PAT_LOAD edge:
  - pattern <= PAT_IN, mask <= MASK_IN; history and fill cleared; state EMPTY.
  - Any IN sampled at the same edge is discarded, and no match is flagged at that edge.
- MATCH_CNT: increments on each match edge and saturates at 2^CNT_W-1 (no wrap).
  - CNT_CLR sets it to 0.
  - If CNT_CLR and a match occur on the same edge, the result is 1 (clear then count).
- All-ones mask: matches on every valid bit once ARMED (OVERLAP=1).

Test Plan:
- Defaults; RST held 3 cycles then released; IN=1,0,0,1,1 with IN_VALID=1 -> MATCH=1 only in the cycle after the 5th bit edge; MATCH_CNT=1; ARMED=1 from the cycle after the 5th bit.
- PAT_LOAD 5'b10101, mask 0, OVERLAP=1; stream 1,0,1,0,1,0,1 -> matches after bits 5 and 7, MATCH_CNT=2. Repeat with OVERLAP=0 -> single match after bit 5, MATCH_CNT=1, ARMED=0 after the match.
- Mask 5'b00100, pattern 10011; stream 1,0,1,1,1 -> MATCH; stream 0,0,1,1,1 -> no MATCH.
- Pattern 10011 sent with IN_VALID=0 gaps of 2 cycles between bits -> one MATCH pulse, one cycle long, following the last valid edge. PAT_LOAD after 3 bits of 1,0,0 then 1,1 -> no MATCH.
- CNT_W=2, all-ones mask, OVERLAP=1, 8 valid bits -> MATCH_CNT saturates at 3. CNT_CLR coincident with a match -> MATCH_CNT=1.
- RST asserted mid-pattern (after 1,0,0) then 1,1 -> no MATCH; all outputs 0 in the cycle after the reset edge.
